// File: rtl/dual_port_ram_ctl_if.sv
// Handshake/data bundle for the dual-port RAM controller.
// Parity error outputs exist only when DPRAM_PARITY_EN is defined.
interface dual_port_ram_ctl_if #(
    parameter int AW = 10,
    parameter int DW = 8
);
    localparam int BW = DW / 8;

    logic          O_ready;
    logic          I_cs0;
    logic          I_rdwr0;
    logic [AW-1:0] I_addr0;
    logic [DW-1:0] I_wr_data0;
    logic [BW-1:0] I_be0;
    logic [DW-1:0] O_rd_data0;
    logic          O_valid0;
    logic          I_cs1;
    logic          I_rdwr1;
    logic [AW-1:0] I_addr1;
    logic [DW-1:0] I_wr_data1;
    logic [BW-1:0] I_be1;
    logic [DW-1:0] O_rd_data1;
    logic          O_valid1;
    logic          O_collision;
`ifdef DPRAM_PARITY_EN
    logic          O_parity_err0;
    logic          O_parity_err1;
`endif

    modport master (
        output I_cs0, I_rdwr0, I_addr0, I_wr_data0, I_be0,
        output I_cs1, I_rdwr1, I_addr1, I_wr_data1, I_be1,
`ifdef DPRAM_PARITY_EN
        input  O_parity_err0, O_parity_err1,
`endif
        input  O_ready, O_rd_data0, O_valid0,
        input  O_rd_data1, O_valid1, O_collision
    );

    modport slave (
        input  I_cs0, I_rdwr0, I_addr0, I_wr_data0, I_be0,
        input  I_cs1, I_rdwr1, I_addr1, I_wr_data1, I_be1,
`ifdef DPRAM_PARITY_EN
        output O_parity_err0, O_parity_err1,
`endif
        output O_ready, O_rd_data0, O_valid0,
        output O_rd_data1, O_valid1, O_collision
    );
endinterface

// File: rtl/dual_port_ram_ctl.sv
// Single-clock true dual-port RAM: byte enables, port-0-wins collisions,
// zero-fill sweep after reset. Optional per-lane parity: DPRAM_PARITY_EN.
module dual_port_ram_ctl #(
    parameter int P_depth      = 1024,
    parameter int P_data_width = 8,
    parameter int P_latency    = 1,
    parameter int P_rdw_new    = 0
) (
    input logic                I_clock,
    input logic                I_reset_n,
    dual_port_ram_ctl_if.slave bus
);
    localparam int AW = $clog2(P_depth);
    localparam int DW = P_data_width;
    localparam int BW = DW / 8;
    localparam logic [AW-1:0] LAST = AW'(P_depth - 1);
    localparam bit POW2 = (P_depth == (1 << AW));

    typedef enum logic {INIT, RUN} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] init_cnt;
    logic          ready, init_we;

    logic [DW-1:0] mem [P_depth];

    logic          acc0, acc1, wr0, wr1, in0, in1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] wd0, wd1;
    logic [BW-1:0] be0, be1;
    logic [DW-1:0] old0, old1, new0, new1, ret0, ret1;

    logic          v1_0, v1_1, coll_q;
    logic [DW-1:0] d1_0, d1_1;

    always_ff @(posedge I_clock or negedge I_reset_n) begin
        if (!I_reset_n) state <= INIT;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            INIT: if (init_cnt == LAST) state_nx = RUN;
            RUN:  state_nx = RUN;
        endcase
    end

    always_comb begin
        ready   = (state == RUN);
        init_we = (state == INIT);
    end

    always_ff @(posedge I_clock or negedge I_reset_n) begin
        if (!I_reset_n)   init_cnt <= '0;
        else if (init_we) init_cnt <= init_cnt + 1'b1;
    end

    assign a0   = bus.I_addr0;
    assign a1   = bus.I_addr1;
    assign wd0  = bus.I_wr_data0;
    assign wd1  = bus.I_wr_data1;
    assign be0  = bus.I_be0;
    assign be1  = bus.I_be1;
    assign acc0 = bus.I_cs0 & ready;
    assign acc1 = bus.I_cs1 & ready;
    assign wr0  = acc0 & ~bus.I_rdwr0 & in0;
    assign wr1  = acc1 & ~bus.I_rdwr1 & in1;

    // Addresses past the last word only exist for non-power-of-2 depths.
    if (POW2) begin : g_pow2
        assign in0 = 1'b1;
        assign in1 = 1'b1;
    end else begin : g_npow2
        assign in0 = (a0 <= LAST);
        assign in1 = (a1 <= LAST);
    end

    // Port 1 lanes are applied first so port 0 overrides shared lanes.
    always_ff @(posedge I_clock) begin
        if (init_we) begin
            mem[init_cnt] <= '0;
        end else begin
            for (int k = 0; k < BW; k++) begin
                if (wr1 && be1[k]) mem[a1][8*k +: 8] <= wd1[8*k +: 8];
                if (wr0 && be0[k]) mem[a0][8*k +: 8] <= wd0[8*k +: 8];
            end
        end
    end

    always_comb begin
        old0 = in0 ? mem[a0] : '0;
        old1 = in1 ? mem[a1] : '0;
        new0 = old0;
        new1 = old1;
        for (int k = 0; k < BW; k++) begin
            if (wr1 && be1[k] && a1 == a0) new0[8*k +: 8] = wd1[8*k +: 8];
            if (wr0 && be0[k])             new0[8*k +: 8] = wd0[8*k +: 8];
            if (wr1 && be1[k])             new1[8*k +: 8] = wd1[8*k +: 8];
            if (wr0 && be0[k] && a0 == a1) new1[8*k +: 8] = wd0[8*k +: 8];
        end
        ret0 = (P_rdw_new != 0) ? new0 : old0;
        ret1 = (P_rdw_new != 0) ? new1 : old1;
    end

`ifdef DPRAM_PARITY_EN
    logic [BW-1:0] par [P_depth];
    logic [BW-1:0] op0, op1, np0, np1, rp0, rp1;
    logic          pe0, pe1, e1_0, e1_1;

    function automatic logic [BW-1:0] lane_par(input logic [DW-1:0] w);
        logic [BW-1:0] p;
        for (int k = 0; k < BW; k++) p[k] = ^w[8*k +: 8];
        return p;
    endfunction

    always_ff @(posedge I_clock) begin
        if (init_we) begin
            par[init_cnt] <= '0;
        end else begin
            for (int k = 0; k < BW; k++) begin
                if (wr1 && be1[k]) par[a1][k] <= ^wd1[8*k +: 8];
                if (wr0 && be0[k]) par[a0][k] <= ^wd0[8*k +: 8];
            end
        end
    end

    always_comb begin
        op0 = in0 ? par[a0] : '0;
        op1 = in1 ? par[a1] : '0;
        np0 = op0;
        np1 = op1;
        for (int k = 0; k < BW; k++) begin
            if (wr1 && be1[k] && a1 == a0) np0[k] = ^wd1[8*k +: 8];
            if (wr0 && be0[k])             np0[k] = ^wd0[8*k +: 8];
            if (wr1 && be1[k])             np1[k] = ^wd1[8*k +: 8];
            if (wr0 && be0[k] && a0 == a1) np1[k] = ^wd0[8*k +: 8];
        end
        rp0 = (P_rdw_new != 0) ? np0 : op0;
        rp1 = (P_rdw_new != 0) ? np1 : op1;
        pe0 = |(lane_par(ret0) ^ rp0);
        pe1 = |(lane_par(ret1) ^ rp1);
    end

    always_ff @(posedge I_clock or negedge I_reset_n) begin
        if (!I_reset_n) begin
            e1_0 <= 1'b0;
            e1_1 <= 1'b0;
        end else begin
            e1_0 <= acc0 & pe0;
            e1_1 <= acc1 & pe1;
        end
    end
`endif

    always_ff @(posedge I_clock or negedge I_reset_n) begin
        if (!I_reset_n) begin
            v1_0   <= 1'b0;
            v1_1   <= 1'b0;
            d1_0   <= '0;
            d1_1   <= '0;
            coll_q <= 1'b0;
        end else begin
            v1_0   <= acc0;
            v1_1   <= acc1;
            coll_q <= acc0 & acc1 & (a0 == a1)
                    & (~bus.I_rdwr0 | ~bus.I_rdwr1);
            if (acc0) d1_0 <= ret0;
            if (acc1) d1_1 <= ret1;
        end
    end

    assign bus.O_ready     = ready;
    assign bus.O_collision = coll_q;

    if (P_latency == 2) begin : g_lat2
        logic          v2_0, v2_1;
        logic [DW-1:0] d2_0, d2_1;

        always_ff @(posedge I_clock or negedge I_reset_n) begin
            if (!I_reset_n) begin
                v2_0 <= 1'b0;
                v2_1 <= 1'b0;
                d2_0 <= '0;
                d2_1 <= '0;
            end else begin
                v2_0 <= v1_0;
                v2_1 <= v1_1;
                if (v1_0) d2_0 <= d1_0;
                if (v1_1) d2_1 <= d1_1;
            end
        end

        assign bus.O_valid0   = v2_0;
        assign bus.O_valid1   = v2_1;
        assign bus.O_rd_data0 = d2_0;
        assign bus.O_rd_data1 = d2_1;

`ifdef DPRAM_PARITY_EN
        logic e2_0, e2_1;

        always_ff @(posedge I_clock or negedge I_reset_n) begin
            if (!I_reset_n) begin
                e2_0 <= 1'b0;
                e2_1 <= 1'b0;
            end else begin
                e2_0 <= e1_0;
                e2_1 <= e1_1;
            end
        end

        assign bus.O_parity_err0 = e2_0;
        assign bus.O_parity_err1 = e2_1;
`endif
    end else begin : g_lat1
        assign bus.O_valid0   = v1_0;
        assign bus.O_valid1   = v1_1;
        assign bus.O_rd_data0 = d1_0;
        assign bus.O_rd_data1 = d1_1;
`ifdef DPRAM_PARITY_EN
        assign bus.O_parity_err0 = e1_0;
        assign bus.O_parity_err1 = e1_1;
`endif
    end
endmodule
